record2uart: RTL

RECORD2UART -- requirements
Module: record2uart

---
 rtl/record2uart_pkg.sv | 22 ++
 rtl/record2uart.sv | 136 +++++++++++++
 2 files changed

// File: rtl/record2uart_pkg.sv
// Shared types and helpers for record2uart: FSM state encoding and the
// nibble-to-ASCII conversion used by the hex output mode.
package record2uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    SEND,
    WAIT_ACK,
    WAIT_IDLE,
    TRAILER,
    WAIT_TRL_ACK
  } state_t;

  // Uppercase hex digit: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + 8'(nib);
    return 8'h37 + 8'(nib);
  endfunction

endpackage

// File: rtl/record2uart.sv
// Pops fixed-size records from a FIFO and streams them MSB-first to a byte UART,
// optionally followed by a trailer byte. Define RECORD2UART_HEX_EN for ASCII-hex output.
module record2uart
  import record2uart_pkg::*;
#(
  parameter int         RECORD_BYTES = 6,
  parameter logic [7:0] TRAILER_BYTE = 8'h0A,
  parameter bit         TRAILER_ON   = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [8*RECORD_BYTES-1:0] read_data,
  input  logic                      read_empty,
  output logic                      read_clk_enable,
  input  logic                      uart_ready,
  output logic                      uart_clk_enable,
  output logic [7:0]                uart_data,
  output logic                      busy,
  output logic [15:0]               rec_count
);

`ifdef RECORD2UART_HEX_EN
  localparam int CHARS = 2 * RECORD_BYTES;
`else
  localparam int CHARS = RECORD_BYTES;
`endif
  localparam int IDX_W = $clog2(2 * RECORD_BYTES + 1);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(CHARS - 1);

  state_t                    state, state_next;
  logic [IDX_W-1:0]          idx, idx_next;
  logic [8*RECORD_BYTES-1:0] record_q;
  logic                      pop_next, uart_en_next;
  logic [7:0]                uart_data_next, cur_byte, cur_char;
  logic [15:0]               count_next;

  // The index counts down to zero, so the highest position is the first character out.
`ifdef RECORD2UART_HEX_EN
  assign cur_byte = 8'(record_q >> {idx >> 1, 3'b000});
  assign cur_char = idx[0] ? nibble_to_ascii(cur_byte[7:4]) : nibble_to_ascii(cur_byte[3:0]);
`else
  assign cur_byte = 8'(record_q >> {idx, 3'b000});
  assign cur_char = cur_byte;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next     = state;
    idx_next       = idx;
    pop_next       = 1'b0;
    uart_en_next   = uart_clk_enable;
    uart_data_next = uart_data;
    count_next     = rec_count;
    case (state)
      IDLE: begin
        if (!read_empty) begin
          pop_next   = 1'b1;
          state_next = POP;
        end
      end
      POP:  state_next = LOAD;
      LOAD: begin
        idx_next   = IDX_FIRST;
        state_next = SEND;
      end
      SEND: begin
        if (uart_ready) begin
          uart_data_next = cur_char;
          uart_en_next   = 1'b1;
          state_next     = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!uart_ready) begin
          uart_en_next = 1'b0;
          state_next   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (uart_ready) begin
          if (idx != '0) begin
            idx_next   = idx - IDX_W'(1);
            state_next = SEND;
          end else if (TRAILER_ON) begin
            state_next = TRAILER;
          end else begin
            count_next = rec_count + 16'd1;
            state_next = IDLE;
          end
        end
      end
      TRAILER: begin
        if (uart_ready) begin
          uart_data_next = TRAILER_BYTE;
          uart_en_next   = 1'b1;
          state_next     = WAIT_TRL_ACK;
        end
      end
      WAIT_TRL_ACK: begin
        if (!uart_ready) begin
          uart_en_next = 1'b0;
          count_next   = rec_count + 16'd1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      idx             <= '0;
      read_clk_enable <= 1'b0;
      uart_clk_enable <= 1'b0;
      uart_data       <= 8'h00;
      rec_count       <= 16'h0000;
    end else begin
      state           <= state_next;
      idx             <= idx_next;
      read_clk_enable <= pop_next;
      uart_clk_enable <= uart_en_next;
      uart_data       <= uart_data_next;
      rec_count       <= count_next;
    end
  end

  // NOTE: the record register is pure datapath; it is always reloaded in LOAD before use, so it has no reset.
  always_ff @(posedge clk) begin
    if (state == LOAD) record_q <= read_data;
  end

endmodule
